// File: rtl/my_sub.sv
// Bit-serial subtractor: Dout = Ain - Bin - Bi (mod 2^WIDTH), one bit per clock, LSB first.
// A single borrow flip-flop carries the borrow between bits; Start/Done handshake with the sequencer.
module my_sub #(
  parameter int WIDTH = 6
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] Ain,
  input  logic [WIDTH-1:0] Bin,
  input  logic             Bi,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Dout,
  output logic             Bo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  // The bit being produced this cycle completes the result, so only WIDTH-1 earlier bits are stored.
  logic [WIDTH-1:1] d_sh_r;
  logic             br_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] dout_r;
  logic             bo_r;
  logic             busy_r;
  logic             done_r;
  logic             d_s;
  logic             br_nxt_s;
  logic             accept_s;
  logic             last_s;

  // Full-subtractor cell on the current LSBs and the stored borrow.
  always_comb begin
    d_s      = a_sh_r[0] ^ b_sh_r[0] ^ br_r;
    br_nxt_s = (~a_sh_r[0] & b_sh_r[0]) | (~(a_sh_r[0] ^ b_sh_r[0]) & br_r);
  end

  // Next-state decode; Start is only honoured outside RUN.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    last_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (Start) begin
          state_nxt_s = RUN;
          accept_s    = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == LAST_BIT) begin
          state_nxt_s = DONE;
          last_s      = 1'b1;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE: begin
        if (Start) begin
          state_nxt_s = RUN;
          accept_s    = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register with registered Busy/Done decoded from the next state.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == RUN);
      done_r  <= (state_nxt_s == DONE);
    end
  end

  // Operand load, serial shifting and result capture.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      a_sh_r <= {WIDTH{1'b0}};
      b_sh_r <= {WIDTH{1'b0}};
      d_sh_r <= {(WIDTH-1){1'b0}};
      br_r   <= 1'b0;
      cnt_r  <= {CW{1'b0}};
      dout_r <= {WIDTH{1'b0}};
      bo_r   <= 1'b0;
    end else if (accept_s) begin
      a_sh_r <= Ain;
      b_sh_r <= Bin;
      br_r   <= Bi;
      cnt_r  <= {CW{1'b0}};
    end else if (state_r == RUN) begin
      a_sh_r <= {1'b0, a_sh_r[WIDTH-1:1]};
      b_sh_r <= {1'b0, b_sh_r[WIDTH-1:1]};
      d_sh_r <= {d_s, d_sh_r[WIDTH-1:2]};
      br_r   <= br_nxt_s;
      cnt_r  <= cnt_r + CW'(1);
      if (last_s) begin
        dout_r <= {d_s, d_sh_r};
        bo_r   <= br_nxt_s;
      end
    end
  end

  assign Busy = busy_r;
  assign Done = done_r;
  assign Dout = dout_r;
  assign Bo   = bo_r;

endmodule

// File: tb/tb_my_sub.sv
// Self-checking bench for my_sub: directed cases plus randomized operations against an arithmetic model.
module tb_my_sub;

  localparam int W = 6;

  logic         Clk;
  logic         Rst_n;
  logic         Start;
  logic [W-1:0] Ain;
  logic [W-1:0] Bin;
  logic         Bi;
  logic         Busy;
  logic         Done;
  logic [W-1:0] Dout;
  logic         Bo;

  int vectors;
  int miscompares;
  int prev_dout;
  int prev_bo;

  my_sub #(.WIDTH(W)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .Start (Start),
    .Ain   (Ain),
    .Bin   (Bin),
    .Bi    (Bi),
    .Busy  (Busy),
    .Done  (Done),
    .Dout  (Dout),
    .Bo    (Bo)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input int observed, input int expected);
    vectors++;
    if (observed != expected) begin
      miscompares++;
      $display("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Reference: plain integer subtraction, wrapped modulo 2^W; borrow when the true result is negative.
  function automatic int model_dout(input int a, input int b, input int bi);
    int m;
    m = 1 << W;
    return (((a - b - bi) % m) + m) % m;
  endfunction

  function automatic int model_bo(input int a, input int b, input int bi);
    return (a < b + bi) ? 1 : 0;
  endfunction

  task automatic launch(input int a, input int b, input int bi);
    Start = 1'b1;
    Ain   = W'(a);
    Bin   = W'(b);
    Bi    = bi[0];
  endtask

  // Runs from the accepting edge to the Done cycle; poke>0 raises a stray Start mid-RUN.
  task automatic finish_op(input int a, input int b, input int bi, input bit hold, input int poke);
    int ed;
    int eb;
    ed = model_dout(a, b, bi);
    eb = model_bo(a, b, bi);
    step();
    check_eq("busy_after_accept", int'(Busy), 1);
    check_eq("done_after_accept", int'(Done), 0);
    if (!hold) Start = 1'b0;
    Ain = W'($urandom);
    Bin = W'($urandom);
    Bi  = 1'($urandom);
    for (int i = 1; i < W; i++) begin
      step();
      check_eq("busy_run", int'(Busy), 1);
      check_eq("done_run", int'(Done), 0);
      check_eq("dout_held_run", int'(Dout), prev_dout);
      check_eq("bo_held_run", int'(Bo), prev_bo);
      if (i == poke) begin
        Start = 1'b1;
        Ain   = W'(1);
        Bin   = W'(2);
      end else if (!hold) begin
        Start = 1'b0;
      end
    end
    step();
    check_eq("done_pulse", int'(Done), 1);
    check_eq("busy_done", int'(Busy), 0);
    check_eq("dout", int'(Dout), ed);
    check_eq("bo", int'(Bo), eb);
    prev_dout = ed;
    prev_bo   = eb;
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      check_eq("idle_busy", int'(Busy), 0);
      check_eq("idle_done", int'(Done), 0);
      check_eq("idle_dout", int'(Dout), prev_dout);
      check_eq("idle_bo", int'(Bo), prev_bo);
    end
  endtask

  int dir_a [5] = '{37, 5, 0, 63, 63};
  int dir_b [5] = '{20, 9, 0, 63, 0};
  int dir_i [5] = '{0, 0, 1, 1, 0};
  int dir_d [5] = '{17, 60, 63, 63, 63};
  int dir_o [5] = '{0, 1, 1, 1, 0};

  initial begin
    vectors     = 0;
    miscompares = 0;
    prev_dout   = 0;
    prev_bo     = 0;
    Rst_n = 1'b0;
    Start = 1'b0;
    Ain   = '0;
    Bin   = '0;
    Bi    = 1'b0;

    step();
    step();
    Rst_n = 1'b1;
    step();
    check_eq("rst_busy", int'(Busy), 0);
    check_eq("rst_done", int'(Done), 0);
    check_eq("rst_dout", int'(Dout), 0);
    check_eq("rst_bo", int'(Bo), 0);
    idle_check(3);

    for (int i = 0; i < 5; i++) begin
      launch(dir_a[i], dir_b[i], dir_i[i]);
      finish_op(dir_a[i], dir_b[i], dir_i[i], 1'b0, 0);
      check_eq("spec_dout", int'(Dout), dir_d[i]);
      check_eq("spec_bo", int'(Bo), dir_o[i]);
      idle_check(1);
    end

    // Stray Start during RUN must not resample the operands.
    launch(10, 3, 0);
    finish_op(10, 3, 0, 1'b0, 3);
    check_eq("ignore_dout", int'(Dout), 7);
    check_eq("ignore_bo", int'(Bo), 0);
    idle_check(2);
    launch(20, 1, 0);
    finish_op(20, 1, 0, 1'b0, 0);
    idle_check(1);

    // Back-to-back with Start held through the DONE cycle.
    launch(12, 4, 0);
    finish_op(12, 4, 0, 1'b1, 0);
    check_eq("b2b_first_dout", int'(Dout), 8);
    launch(4, 12, 0);
    finish_op(4, 12, 0, 1'b0, 0);
    check_eq("b2b_second_dout", int'(Dout), 56);
    check_eq("b2b_second_bo", int'(Bo), 1);
    idle_check(1);

    // Reset in the middle of RUN aborts with no Done.
    launch(50, 1, 0);
    step();
    Start = 1'b0;
    step();
    step();
    step();
    Rst_n = 1'b0;
    step();
    Rst_n = 1'b1;
    check_eq("abort_busy", int'(Busy), 0);
    check_eq("abort_done", int'(Done), 0);
    check_eq("abort_dout", int'(Dout), 0);
    check_eq("abort_bo", int'(Bo), 0);
    prev_dout = 0;
    prev_bo   = 0;
    idle_check(W + 2);
    launch(50, 1, 0);
    finish_op(50, 1, 0, 1'b0, 0);
    check_eq("after_abort_dout", int'(Dout), 49);
    idle_check(1);

    // Randomized operations, some chained back-to-back.
    for (int n = 0; n < 40; n++) begin
      int  a;
      int  b;
      int  bi;
      bit  hold;
      a    = int'($urandom_range(0, (1 << W) - 1));
      b    = int'($urandom_range(0, (1 << W) - 1));
      bi   = int'($urandom_range(0, 1));
      hold = (n < 39) ? bit'($urandom_range(0, 1)) : 1'b0;
      launch(a, b, bi);
      finish_op(a, b, bi, hold, 0);
      if (!hold) idle_check(int'($urandom_range(1, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
